// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one shift/adjust step per clock.
// Optional `BCD_BLANK_EN adds a registered leading-zero blanking mask output.
module bin2bcd_seq #(
  parameter int W      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic [4*DIGITS-1:0]   bcd,
`ifdef BCD_BLANK_EN
  output logic [DIGITS-1:0]     blank,
`endif
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // Handshake: start is sampled only in IDLE; bin is captured on that same edge.
  // busy covers the W shift cycles; done pulses for one cycle as bcd updates.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   shreg, shreg_d, adj;
  logic [CW-1:0]   count, count_d;
  logic [BW-1:0]   bcd_d;
  logic            busy_d, done_d;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BCD_BLANK_EN
      blank <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      count <= count_d;
      bcd   <= bcd_d;
      busy  <= busy_d;
      done  <= done_d;
`ifdef BCD_BLANK_EN
      blank <= blank_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    count_d = count;
    bcd_d   = bcd;
    busy_d  = busy;
    done_d  = 1'b0;
    adj     = shreg;
`ifdef BCD_BLANK_EN
    blank_d = blank;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          shreg_d = {{BW{1'b0}}, bin};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Add 3 to any scratch digit >= 5 before the shift doubles it.
        for (int i = 0; i < DIGITS; i++) begin
          if (adj[W+4*i +: 4] >= 4'd5)
            adj[W+4*i +: 4] = adj[W+4*i +: 4] + 4'd3;
        end
        shreg_d = {adj[SW-2:0], 1'b0};
        count_d = count + 1'b1;
        if (count == CW'(W-1)) begin
          bcd_d   = shreg_d[W +: BW];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BCD_BLANK_EN
          // Blank a digit only when it and every digit above it are zero.
          blank_d[DIGITS-1] = (shreg_d[W+4*(DIGITS-1) +: 4] == 4'd0);
          for (int i = DIGITS-2; i >= 0; i--)
            blank_d[i] = blank_d[i+1] && (shreg_d[W+4*i +: 4] == 4'd0);
          blank_d[0] = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed testbench for bin2bcd_seq with hand-computed BCD results.
// Also checks the blank mask when built with BCD_BLANK_EN.
module tb_bin2bcd_seq;

  localparam int W      = 10;
  localparam int DIGITS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W-1:0]      bin;
  logic [15:0]       bcd;
  logic              busy;
  logic              done;
`ifdef BCD_BLANK_EN
  logic [3:0]        blank;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
`ifdef BCD_BLANK_EN
    .blank (blank),
`endif
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag, input logic [3:0] exp);
`ifdef BCD_BLANK_EN
    check(tag, 32'(blank), 32'(exp));
`endif
  endtask

  // Wait (bounded) for done; returns negedges elapsed and busy-high count.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    check(tag, 32'(bcd), 32'(e));
  endtask

  task automatic run_conv(input string tag, input logic [W-1:0] b,
                          input logic [15:0] exp_bcd, input logic [3:0] exp_blank);
    int cyc, bc;
    @(negedge clk);
    bin = b;
    start = 1'b1;
    exp_q.push_back(exp_bcd);
    @(negedge clk);
    start = 1'b0;
    bin = '0;
    wait_done(cyc, bc);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'd10);
    check({tag, "_busycnt"}, 32'(bc), 32'd10);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    pop_check({tag, "_bcd"});
    check_blank({tag, "_blank"}, exp_blank);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(bcd), 32'(exp_bcd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, bc, npulse;
    rst = 1'b1;
    start = 1'b0;
    bin = '0;
    repeat (2) @(negedge clk);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_blank("rst_blank", 4'b1110);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);

    run_conv("v961", 10'd961, 16'h0961, 4'b1000);
    run_conv("v0", 10'd0, 16'h0000, 4'b1110);
    run_conv("v1023", 10'd1023, 16'h1023, 4'b0000);
    run_conv("v5", 10'd5, 16'h0005, 4'b1110);

    // start while busy must be ignored
    @(negedge clk);
    bin = 10'd123;
    start = 1'b1;
    exp_q.push_back(16'h0123);
    @(negedge clk);
    bin = 10'd999;
    repeat (3) @(negedge clk);
    start = 1'b0;
    bin = '0;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        npulse++;
        pop_check("ign_bcd");
        check_blank("ign_blank", 4'b1000);
      end
      @(negedge clk);
    end
    check("ign_pulses", 32'(npulse), 32'd1);
    check("ign_hold", 32'(bcd), 32'h0123);

    // reset in the middle of a conversion
    @(negedge clk);
    bin = 10'd500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_blank("abort_blank", 4'b1110);
    rst = 1'b0;
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) npulse++;
      @(negedge clk);
    end
    check("abort_nodone", 32'(npulse), 32'd0);
    run_conv("v77", 10'd77, 16'h0077, 4'b1100);

    // back-to-back: start held through the done cycle
    @(negedge clk);
    bin = 10'd31;
    start = 1'b1;
    exp_q.push_back(16'h0031);
    exp_q.push_back(16'h0961);
    @(negedge clk);
    bin = 10'd961;
    wait_done(cyc, bc);
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_lat1", 32'(cyc), 32'd10);
    pop_check("b2b_bcd1");
    check_blank("b2b_blank1", 4'b1100);
    @(negedge clk);
    start = 1'b0;
    bin = '0;
    check("b2b_drop", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_gap", 32'(cyc), 32'd11);
    pop_check("b2b_bcd2");
    check_blank("b2b_blank2", 4'b1000);
    check("q_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly downstream of the calculator's multiplier stage. It consumes the 10-bit product (5-bit x 5-bit, max 961) and produces packed BCD digits for the display driver.
- Uses one shift/adjust iteration per clock, so area stays small in place of a combinational converter.

Parameters:
- W, 10, binary input width in bits.
- DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^W - 1; integrator's responsibility, not checked in RTL.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  W  binary value; captured on the edge that accepts start.
- bcd  output  4*DIGITS  result; bcd[3:0] is ones, bcd[7:4] tens, and so on; registered.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd has just been updated.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - bcd = 0, busy = 0, done = 0.
  - Internal shift register and iteration counter are cleared.
  - rst has priority over every other input.
- Reset mid-operation aborts the conversion. bcd returns to 0 and no done pulse is produced.
- States: IDLE, SHIFT.
- IDLE:
  - done = 0 except during its single pulse cycle.
  - On an edge with start=1: load the W-bit shift field with bin, clear the BCD scratch field, set count = 0, busy = 1, go to SHIFT.
  - start=0: remain in IDLE; bcd holds its value.
- SHIFT, at each edge:
  - For every scratch digit >= 5, add 3 to that digit (4-bit add, no carry out of the digit).
  - Then shift the concatenated {scratch, binary} register left by 1.
  - count increments.
  - On the W-th iteration (count == W-1 before the edge), that same edge also:
    - loads bcd with the post-shift scratch field,
    - sets done = 1 and busy = 0,
    - returns to IDLE.
- done deasserts on the next edge.
- Latency: start accepted at edge E0 gives busy=1 after E0, W iterations at E1..EW, and done=1 and bcd valid in the cycle after EW. For W=10 that is 10 clocks from acceptance to done.
- Throughput: one conversion per W+1 cycles minimum.
- start while busy is ignored; bin changes during SHIFT have no effect.
- Back-to-back: start=1 in the cycle where done=1 (state is IDLE) is accepted. done then drops and busy rises after that edge.
- bcd changes only on the completing edge or on reset; it holds the last result otherwise.
- Every digit of bcd is always 0–9 for legal inputs.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined:
  - Adds output port blank, width DIGITS, registered and updated on the same edge as bcd.
  - blank[i] = 1 when digit i and all higher digits are zero, for i >= 1.
  - blank[0] is always 0, so the ones digit is never blanked.
  - Reset value of blank is all-ones except bit 0, i.e. {DIGITS-1{1}},0, which is 4'b1110 for DIGITS=4.
- Not defined: blank port and its logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then release -> bcd=16'h0000, busy=0, done=0. With BCD_BLANK_EN, blank=4'b1110.
- bin=961, start pulse -> busy high for 10 cycles, done single pulse, bcd=16'h0961 and held afterwards. With BCD_BLANK_EN, blank=4'b1000.
- bin=0 gives bcd=16'h0000; bin=1023 gives bcd=16'h1023; bin=5 gives bcd=16'h0005 and, with BCD_BLANK_EN, blank=4'b1110.
- Start bin=123; during SHIFT assert start with bin=999 -> second request ignored, bcd=16'h0123, exactly one done pulse.
- Start bin=500; assert rst on the 5th SHIFT cycle -> bcd=0, busy=0, no done pulse. Then a new start with bin=77 gives bcd=16'h0077.
- Back-to-back: start bin=31, then hold start=1 with bin=961 through the done cycle -> first done with bcd=16'h0031, second done 11 cycles later with bcd=16'h0961.
